// File: rtl/wide_addsub_seq_if.sv
// Handshake bundle for wide_addsub_seq: operand channel in, result channel out.
// Both channels use valid/ready; a transfer happens on a rising edge where both are high.
interface wide_addsub_seq_if #(
    parameter int NUM_WORDS = 4
);
    localparam int W = 32 * NUM_WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         sub_flag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output in_valid, src1, src2, sub_flag, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, src1, src2, sub_flag, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/wide_addsub_seq.sv
// Wide add/subtract built from one 32-bit adder slice, issued LSW first over NUM_WORDS cycles.
// Valid/ready: data moves on a rising edge with valid && ready; a valid producer holds its data until accepted.
module wide_addsub_seq #(
    parameter int NUM_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    wide_addsub_seq_if.slave   bus,
    output logic [1:0]         state_dbg
);
    localparam int W  = 32 * NUM_WORDS;
    localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res;
    logic          c;
    logic [KW-1:0] k;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  sum_r;
    logic          carry_r;
    logic          overflow_r;
    logic          zero_r;

    // The single 32-bit adder slice, fed by the word selected by k.
    logic [31:0]  a_word;
    logic [31:0]  b_word;
    logic [32:0]  slice;
    logic [W-1:0] res_next;

    always_comb begin
        a_word   = a_reg[{k, 5'b0} +: 32];
        b_word   = b_reg[{k, 5'b0} +: 32];
        slice    = {1'b0, a_word} + {1'b0, b_word} + {32'b0, c};
        res_next = res;
        res_next[{k, 5'b0} +: 32] = slice[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            res         <= '0;
            c           <= 1'b0;
            k           <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.src1;
                        b_reg      <= bus.sub_flag ? ~bus.src2 : bus.src2;
                        c          <= bus.sub_flag;
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res <= res_next;
                    c   <= slice[32];
                    if (k == K_LAST) begin
                        // Overflow uses the inverted B so add and subtract share one rule.
                        sum_r       <= res_next;
                        carry_r     <= slice[32];
                        zero_r      <= (res_next == '0);
                        overflow_r  <= (a_reg[W-1] == b_reg[W-1]) && (slice[31] != a_reg[W-1]);
                        out_valid_r <= 1'b1;
                        k           <= '0;
                        state       <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_wide_addsub_seq.sv
// Directed bench for wide_addsub_seq at NUM_WORDS=4 with hand-computed expected results.
module tb_wide_addsub_seq;
    localparam int NUM_WORDS = 4;
    localparam int W = 32 * NUM_WORDS;

    logic clk;
    logic rst;
    logic [1:0] state_dbg;

    wide_addsub_seq_if #(.NUM_WORDS(NUM_WORDS)) bus ();

    wide_addsub_seq #(.NUM_WORDS(NUM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic c, input logic v, input logic z);
        logic [W-1:0] exp_sum;
        exp_sum = exp_q.pop_front();
        check({tag, " out_valid"}, W'(bus.out_valid), W'(1));
        check({tag, " sum"}, bus.sum, exp_sum);
        check({tag, " carry"}, W'(bus.carry_out), W'(c));
        check({tag, " ovf"}, W'(bus.overflow), W'(v));
        check({tag, " zero"}, W'(bus.zero), W'(z));
    endtask

    // Accept on edge T0; result must be valid exactly NUM_WORDS edges later.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_sum,
                          input logic c, input logic v, input logic z,
                          input logic release_out);
        @(negedge clk);
        check({tag, " in_ready"}, W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.src1     = a;
        bus.src2     = b;
        bus.sub_flag = sub;
        exp_q.push_back(exp_sum);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i < NUM_WORDS; i++) begin
            @(posedge clk);
        end
        #1;
        check({tag, " early out_valid"}, W'(bus.out_valid), W'(0));
        @(posedge clk);
        #1;
        check_flags(tag, c, v, z);
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check({tag, " idle after pop"}, W'(state_dbg), W'(0));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.sub_flag  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst in_ready", W'(bus.in_ready), W'(1));
        check("rst out_valid", W'(bus.out_valid), W'(0));
        check("rst sum", bus.sum, '0);
        check("rst flags", W'({bus.carry_out, bus.overflow, bus.zero}), W'(0));
        check("rst state", W'(state_dbg), W'(0));

        run_op("add_wrap", ONES, W'(1), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("sub_borrow", W'(5), W'(7), 1'b1, ONES - W'(1), 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("add_ovf", ~MSB, W'(1), 1'b0, MSB, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf", MSB, W'(1), 1'b1, ~MSB, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("add_xword", W'(64'hFFFF_FFFF), W'(1), 1'b0, W'(64'h1_0000_0000), 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_xword", W'(64'h1_0000_0000), W'(1), 1'b1, W'(64'hFFFF_FFFF), 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held while new operands are offered and ignored.
        run_op("bp", W'(10), W'(20), 1'b0, W'(30), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.src1     = W'(100 + i);
            bus.src2     = W'(1);
            bus.sub_flag = 1'b1;
            @(posedge clk);
            #1;
            check("bp sum held", bus.sum, W'(30));
            check("bp in_ready", W'(bus.in_ready), W'(0));
            check("bp out_valid", W'(bus.out_valid), W'(1));
        end
        @(negedge clk);
        bus.src1      = W'(100);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp idle", W'(state_dbg), W'(0));
        check("bp in_ready up", W'(bus.in_ready), W'(1));
        exp_q.push_back(W'(99));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp accepted", W'(state_dbg), W'(1));
        repeat (NUM_WORDS) @(posedge clk);
        #1;
        check_flags("bp new", 1'b1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset during the second RUN beat.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.src1     = W'(50);
        bus.src2     = W'(60);
        bus.sub_flag = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid rst state", W'(state_dbg), W'(0));
        check("mid rst in_ready", W'(bus.in_ready), W'(1));
        check("mid rst out_valid", W'(bus.out_valid), W'(0));
        check("mid rst sum", bus.sum, '0);
        check("mid rst flags", W'({bus.carry_out, bus.overflow, bus.zero}), W'(0));
        run_op("post_rst", W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wide_addsub_seq.md
Name: wide_addsub_seq

Overview:
Multi-cycle wide add/subtract sequencer that sits upstream of the team's 32-bit adder slice. It accepts one wide operand pair through a valid/ready handshake. It then issues the operation to the adder one 32-bit word per cycle, least-significant word first, carrying carry-out into the next word's carry-in. It presents the registered wide result and flags through a second valid/ready handshake. This gives 32*NUM_WORDS-bit arithmetic for the area of one 32-bit adder.

Parameters:
NUM_WORDS, 4, number of 32-bit words per operand; legal range 1 to 16. W = 32*NUM_WORDS.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair and sub_flag are valid
in_ready  output  1  block can accept an operand pair
src1  input  W  operand A
src2  input  W  operand B
sub_flag  input  1  0: A+B; 1: A-B
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts the result
sum  output  W  result
carry_out  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed overflow of the W-bit operation
zero  output  1  sum == 0

Behaviour:
- Reset: applied on any clock edge where rst=1; overrides all other inputs.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, zero=0.
  - Word index and internal operand registers are cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, capture the operands:
    - A_reg=src1.
    - B_reg=src2 if sub_flag=0, else ~src2.
    - carry register c=sub_flag.
    - Word index k=0.
  - Then go to RUN.
- RUN (exactly NUM_WORDS cycles):
  - in_ready=0, out_valid=0.
  - Each cycle, the adder slice computes {cout, s} = A_reg[k] + B_reg[k] + c.
  - At the edge: result word k <= s; c <= cout; k <= k+1.
  - On the edge where k == NUM_WORDS-1:
    - sum <= full result, including word k.
    - carry_out <= cout.
    - zero <= (full result == 0).
    - overflow <= (A_msb == B_reg_msb) && (s_msb != A_msb), using the top word.
    - Go to DONE.
  - sum, carry_out, overflow and zero do not change during RUN; they keep their previous or reset values.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and flags are held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops on the next cycle.
  - sum and flags keep their values until the next completion or reset.
- Latency: an accept handshake on edge T0 gives out_valid=1 from edge T0+NUM_WORDS.
  - Minimum issue interval is NUM_WORDS+2 cycles: at least one IDLE cycle between operations.
  - No overlap of operations.
- While in_ready=0, in_valid, src1, src2 and sub_flag are ignored; no capture, no state change.
- NUM_WORDS=1: RUN lasts one cycle; behaviour is otherwise identical.
- Reset mid-RUN or mid-DONE: the partial or pending result is discarded and all outputs return to reset values on that edge. The first operation after reset produces correct results.
- Arithmetic is unsigned modulo 2^W.
  - carry_out is bit W of A + B_reg + sub_flag.
  - overflow follows two's-complement rules for both add and subtract.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. All outputs are driven directly from registers or state decode.

Test Plan:
1. Add, NUM_WORDS=4: src1 = all ones (128 bits), src2 = 1, sub_flag = 0 -> sum = 0, carry_out = 1, zero = 1, overflow = 0; out_valid high exactly 4 cycles after the accept edge.
2. Subtract with borrow: src1 = 5, src2 = 7, sub_flag = 1 -> sum = 0xFFFF...FFFE, carry_out = 0, overflow = 0, zero = 0.
3. Signed overflow: src1 = 0x7FFF...FFFF, src2 = 1, add -> sum = 0x8000...0000, overflow = 1, carry_out = 0. Also src1 = 0x8000...0000, src2 = 1, subtract -> sum = 0x7FFF...FFFF, overflow = 1, carry_out = 1.
4. Inter-word carry: src1 = 0x...0000_0000_FFFF_FFFF, src2 = 1, add -> sum = 0x...0001_0000_0000, carry_out = 0. Also src1 = 0x1_0000_0000, src2 = 1, subtract -> borrow across the word boundary, sum = 0xFFFF_FFFF.
5. Backpressure: hold out_ready = 0 for 3 cycles in DONE while driving in_valid = 1 with new operands -> sum and flags stable, in_ready = 0, no capture. Raise out_ready -> IDLE on the next cycle, then the new operation is accepted.
6. Reset mid-RUN: assert rst for one cycle during beat 2 of 4 -> next cycle state IDLE, in_ready = 1, out_valid = 0, sum = 0, all flags = 0. A following add of 3 + 4 gives sum = 7.
